// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage units.
package riscv_pkg;

  localparam int XLEN = 32;

  // Encodings match funct3 of the M-extension divide group.
  typedef enum logic [2:0] {
    DIV_DIV  = 3'b100,
    DIV_DIVU = 3'b101,
    DIV_REM  = 3'b110,
    DIV_REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/riscv_div_unit.sv
// Multi-cycle RV32M divide/remainder unit, one quotient bit per cycle.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  DIV_IDLE | in_ready=1, waiting for operands
//  DIV_CALC | restoring-division iterations, count_q from XLEN-1 down to 0
//  DIV_DONE | out_valid=1, result held until out_ready
module riscv_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN_P = riscv_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  div_op_e           div_op,
  input  logic [XLEN_P-1:0] dividend,
  input  logic [XLEN_P-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] result
);

  localparam int CW = $clog2(XLEN_P);
  localparam logic [XLEN_P-1:0] MIN_NEG = {1'b1, {(XLEN_P-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic              rem_sel_q, rem_sel_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;
  logic [XLEN_P-1:0] quo_q, quo_d;
  logic [XLEN_P-1:0] rem_q, rem_d;
  logic [XLEN_P-1:0] dvs_q, dvs_d;
  logic [XLEN_P-1:0] result_q, result_d;
  logic [CW-1:0]     count_q, count_d;

  logic              in_signed, in_rem;
  logic [XLEN_P-1:0] a_mag, b_mag;
  logic [XLEN_P:0]   shift_w, diff_w;
  logic [XLEN_P-1:0] quo_step, rem_step;

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = (state_q == DIV_DONE);
  assign result    = result_q;

  // Operand decode, one division step and next-state selection.
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    count_d   = count_q;

    in_signed = (div_op == DIV_DIV) || (div_op == DIV_REM);
    in_rem    = (div_op == DIV_REM) || (div_op == DIV_REMU);
    a_mag     = in_signed ? abs_val(dividend) : dividend;
    b_mag     = in_signed ? abs_val(divisor)  : divisor;

    // Partial remainder keeps its top bit so large divisors still compare correctly;
    // the borrow out of the XLEN+1 bit subtract picks the quotient bit.
    shift_w  = {rem_q, quo_q[XLEN_P-1]};
    diff_w   = shift_w - {1'b0, dvs_q};
    quo_step = {quo_q[XLEN_P-2:0], ~diff_w[XLEN_P]};
    rem_step = diff_w[XLEN_P] ? shift_w[XLEN_P-1:0] : diff_w[XLEN_P-1:0];

    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          rem_sel_d = in_rem;
          sign_q_d  = in_signed & (dividend[XLEN_P-1] ^ divisor[XLEN_P-1]);
          sign_r_d  = in_signed & dividend[XLEN_P-1];
          quo_d     = a_mag;
          rem_d     = '0;
          dvs_d     = b_mag;
          if (divisor == '0) begin
            result_d = in_rem ? dividend : '1;
            state_d  = DIV_DONE;
          end else if (in_signed && (dividend == MIN_NEG) && (divisor == '1)) begin
            result_d = in_rem ? '0 : MIN_NEG;
            state_d  = DIV_DONE;
          end else begin
            count_d = CW'(XLEN_P - 1);
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        quo_d = quo_step;
        rem_d = rem_step;
        if (count_q == '0) begin
          if (rem_sel_q) result_d = sign_r_q ? (~rem_step + 1'b1) : rem_step;
          else           result_d = sign_q_q ? (~quo_step + 1'b1) : quo_step;
          state_d = DIV_DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DIV_DONE: begin
        if (out_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      rem_sel_q <= 1'b0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed and randomised checks of riscv_div_unit against an arithmetic reference.
module tb_riscv_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  div_op_e     div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  riscv_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // RISC-V divide semantics written directly from the ISA rules.
  function automatic logic [31:0] ref_result(div_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REMU: return (b == 0) ? a : a % b;
      DIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      DIV_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(div_op_e op, logic [31:0] a, logic [31:0] b);
    bit signed_op;
    signed_op = (op == DIV_DIV) || (op == DIV_REM);
    if (b == 0) return 1;
    if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One complete transaction: accept, wait for result, optional back-pressure, handshake.
  task automatic do_op(input string tag, input div_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit check_lat);
    int          lat;
    int          guard;
    logic [31:0] exp_res;
    exp_res = ref_result(op, a, b);

    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    div_op    = op;
    dividend  = a;
    divisor   = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    div_op   = div_op_e'({1'b1, 2'($urandom_range(0, 3))});
    dividend = $urandom;
    divisor  = $urandom;

    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (check_lat) chk({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
    chk({tag, "_result"}, result, exp_res);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      div_op   = DIV_DIVU;
      dividend = $urandom;
      divisor  = 32'd1;
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, result, exp_res);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    div_op_e     rop;
    logic [31:0] ra, rb;
    bit          rsigned;

    rst       = 1'b1;
    in_valid  = 1'b0;
    div_op    = DIV_DIVU;
    dividend  = 32'h0;
    divisor   = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;

    do_op("divu_100_7", DIV_DIVU, 32'd100, 32'd7, 0, 1'b1);
    do_op("remu_100_7", DIV_REMU, 32'd100, 32'd7, 0, 1'b1);
    do_op("div_m7_2",   DIV_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    do_op("rem_m7_2",   DIV_REM,  32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    do_op("rem_7_m2",   DIV_REM,  32'd7, 32'hFFFF_FFFE, 0, 1'b1);
    do_op("div_by0",    DIV_DIV,  32'h1234, 32'h0, 0, 1'b1);
    do_op("remu_by0",   DIV_REMU, 32'h1234, 32'h0, 0, 1'b1);
    do_op("div_ovf",    DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    do_op("rem_ovf",    DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    do_op("divu_big",   DIV_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b1);
    do_op("div_hold",   DIV_DIV,  32'd1000, 32'hFFFF_FFF3, 5, 1'b1);
    do_op("next_op",    DIV_REMU, 32'd12345, 32'd100, 0, 1'b1);

    // Abort mid-iteration: count reaches 10 in the 22nd cycle after accept.
    @(negedge clk);
    in_valid = 1'b1;
    div_op   = DIV_DIVU;
    dividend = 32'd999;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    begin
      int seen_valid;
      seen_valid = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (out_valid) seen_valid++;
      end
      chk("abort_no_result", 32'(seen_valid), 32'd0);
    end
    do_op("divu_ffff_1", DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      rop     = div_op_e'({1'b1, 2'($urandom_range(0, 3))});
      rsigned = (rop == DIV_DIV) || (rop == DIV_REM);
      ra      = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'(int'($urandom_range(0, 15)) - 8);
        2:       rb = $urandom >> $urandom_range(0, 31);
        3: begin
          ra = 32'h8000_0000;
          rb = rsigned ? 32'hFFFF_FFFF : $urandom;
        end
        default: rb = $urandom;
      endcase
      do_op("random", rop, ra, rb, $urandom_range(0, 3), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
